// File: rtl/axis_q26_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : axis_q26_frame_accumulator
//  Description : Sums signed Q2.6 samples of an AXI-Stream frame into a
//                saturating accumulator and emits one result beat per frame
//                carrying the sum, the beat count and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_q26_frame_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_WIDTH = 6,
    parameter int INT_WIDTH  = 2,
    parameter int ACC_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int MAX_LEN    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [ACC_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CNT_WIDTH-1:0]  m_count,
    output logic [1:0]            m_tuser
);

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    // Sign-extension amount derived from the Q format; the result keeps the
    // input binary point, so the integer part simply grows into the MSBs.
    localparam int C_SEXT = ACC_WIDTH + 1 - (INT_WIDTH + FRAC_WIDTH);

    localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] C_MAX_LEN = CNT_WIDTH'(MAX_LEN);

    logic [0:0]           r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_sat;
    logic [ACC_WIDTH-1:0] r_m_tdata;
    logic [CNT_WIDTH-1:0] r_m_count;
    logic [1:0]           r_m_tuser;

    logic                 w_xfer;
    logic                 w_m_hs;
    logic [ACC_WIDTH:0]   w_s_ext;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_pos_ovf;
    logic                 w_neg_ovf;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_sat_next;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_at_max;
    logic                 w_close;
    logic                 w_forced;

    // Input is accepted only while accumulating; reset gates it off immediately.
    assign s_tready = (r_state == S_ACC) && !reset;
    assign w_xfer   = s_tvalid && s_tready;
    assign w_m_hs   = (r_state == S_OUT) && m_tready;

    // One extra bit of headroom: overflow shows up as the top two bits differing.
    assign w_s_ext   = {{C_SEXT{s_tdata[DATA_WIDTH-1]}}, s_tdata};
    assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + w_s_ext;
    assign w_pos_ovf = !w_sum[ACC_WIDTH] &&  w_sum[ACC_WIDTH-1];
    assign w_neg_ovf =  w_sum[ACC_WIDTH] && !w_sum[ACC_WIDTH-1];

    // Clamp to the representable range; the saturation flag is sticky per frame.
    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_pos_ovf) begin
            w_acc_next = C_ACC_MAX;
        end else if (w_neg_ovf) begin
            w_acc_next = C_ACC_MIN;
        end
    end

    assign w_sat_next   = r_sat || w_pos_ovf || w_neg_ovf;
    assign w_count_next = r_count + 1'b1;
    assign w_at_max     = (w_count_next == C_MAX_LEN);
    assign w_close      = s_tlast || w_at_max;
    // A frame that ends on its own tlast exactly at the length limit is not forced.
    assign w_forced     = w_at_max && !s_tlast;

    // Frame FSM: accumulate beats, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_ACC;
            r_acc     <= '0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_m_tdata <= '0;
            r_m_count <= '0;
            r_m_tuser <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_xfer) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_count_next;
                        r_sat   <= w_sat_next;
                        if (w_close) begin
                            r_m_tdata <= w_acc_next;
                            r_m_count <= w_count_next;
                            r_m_tuser <= {w_forced, w_sat_next};
                            r_state   <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (w_m_hs) begin
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_sat     <= 1'b0;
                        r_m_tdata <= '0;
                        r_m_count <= '0;
                        r_m_tuser <= '0;
                        r_state   <= S_ACC;
                    end
                end
                default: begin
                    r_state <= S_ACC;
                end
            endcase
        end
    end

    assign m_tvalid = (r_state == S_OUT);
    assign m_tlast  = m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_count  = r_m_count;
    assign m_tuser  = r_m_tuser;

endmodule
`default_nettype wire
